// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the imem/dmem memory-port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ARB_ADDR_W   = 32;
    localparam int unsigned ARB_DATA_W   = 32;
    localparam int unsigned ARB_MASK_W   = 4;
    localparam int unsigned ARB_STREAK_W = 4;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D
    } arb_state_t;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_MASK_W-1:0] rmask;
        logic [ARB_MASK_W-1:0] wmask;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    // Saturating increment of the data-grant streak.
    function automatic logic [ARB_STREAK_W-1:0] streak_inc(
        input logic [ARB_STREAK_W-1:0] cur,
        input logic [ARB_STREAK_W-1:0] max
    );
        return (cur < max) ? cur + ARB_STREAK_W'(1) : max;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and shared memory port seen by the arbiter.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic [ARB_ADDR_W-1:0] imem_addr;
    logic [ARB_MASK_W-1:0] imem_rmask;
    logic [ARB_DATA_W-1:0] imem_rdata;
    logic                  imem_resp;

    logic [ARB_ADDR_W-1:0] dmem_addr;
    logic [ARB_MASK_W-1:0] dmem_rmask;
    logic [ARB_MASK_W-1:0] dmem_wmask;
    logic [ARB_DATA_W-1:0] dmem_wdata;
    logic [ARB_DATA_W-1:0] dmem_rdata;
    logic                  dmem_resp;

    logic [ARB_ADDR_W-1:0] mem_addr;
    logic [ARB_MASK_W-1:0] mem_rmask;
    logic [ARB_MASK_W-1:0] mem_wmask;
    logic [ARB_DATA_W-1:0] mem_wdata;
    logic [ARB_DATA_W-1:0] mem_rdata;
    logic                  mem_resp;

    // Arbiter view: serves both requesters, drives the memory.
    modport slave (
        input  imem_addr, imem_rmask,
        output imem_rdata, imem_resp,
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    // Environment view: requesters plus the memory itself.
    modport master (
        output imem_addr, imem_rmask,
        input  imem_rdata, imem_resp,
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and data ports;
// data has priority, bounded by a streak limit so fetch cannot starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [ARB_STREAK_W-1:0] STREAK_MAX = ARB_STREAK_W'(MAX_D_STREAK);

    arb_state_t              state_q, state_d;
    logic [ARB_STREAK_W-1:0] streak_q, streak_d;
    mem_req_t                req_q, req_d;
    logic                    i_req, d_req;

    assign i_req = |bus.imem_rmask;
    assign d_req = (|bus.dmem_rmask) | (|bus.dmem_wmask);

    // State, streak and latched memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            req_q    <= req_d;
        end
    end

    // Arbitration, issue and response routing.
    always_comb begin
        state_d        = state_q;
        streak_d       = streak_q;
        req_d          = req_q;
        req_d.rmask    = '0;
        req_d.wmask    = '0;
        bus.imem_resp  = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (!i_req) begin
                    streak_d = '0;
                end
                if (d_req && (!i_req || (streak_q < STREAK_MAX))) begin
                    state_d     = ARB_BUSY_D;
                    req_d.addr  = bus.dmem_addr;
                    req_d.rmask = bus.dmem_rmask;
                    req_d.wmask = bus.dmem_wmask;
                    req_d.wdata = bus.dmem_wdata;
                    if (i_req) begin
                        streak_d = streak_inc(streak_q, STREAK_MAX);
                    end
                end else if (i_req) begin
                    state_d     = ARB_BUSY_I;
                    req_d.addr  = bus.imem_addr;
                    req_d.rmask = bus.imem_rmask;
                    req_d.wmask = '0;
                    req_d.wdata = '0;
                    streak_d    = '0;
                end
            end
            ARB_BUSY_I: begin
                // Reset in the same cycle suppresses the response pulse.
                if (bus.mem_resp && !rst) begin
                    bus.imem_resp  = 1'b1;
                    bus.imem_rdata = bus.mem_rdata;
                    state_d        = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                if (bus.mem_resp && !rst) begin
                    bus.dmem_resp  = 1'b1;
                    bus.dmem_rdata = bus.mem_rdata;
                    state_d        = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_rmask = req_q.rmask;
    assign bus.mem_wmask = req_q.wmask;
    assign bus.mem_wdata = req_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.imem_addr  = '0;
        bus.imem_rmask = '0;
        bus.dmem_addr  = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
    endtask

    function automatic logic [31:0] st(input arb_state_t s);
        return 32'(s);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench time limit expired");
    end

    logic       exp_d  [6];
    logic [3:0] exp_sk [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_d    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_sk   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", st(dut.state_q), st(ARB_IDLE));
        check("rst_streak", 32'(dut.streak_q), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_resps", {30'd0, bus.imem_resp, bus.dmem_resp}, 32'd0);
        check("rst_rdata", bus.imem_rdata | bus.dmem_rdata, 32'd0);

        // 1. Lone fetch, memory answers two cycles after the pulse.
        bus.imem_addr  = 32'h6000_0000;
        bus.imem_rmask = 4'hF;
        #1;
        check("t1_no_pulse_t", 32'(bus.mem_rmask), 32'd0);
        tick();
        check("t1_state_busy_i", st(dut.state_q), st(ARB_BUSY_I));
        check("t1_rmask_t1", 32'(bus.mem_rmask), 32'hF);
        check("t1_wmask_t1", 32'(bus.mem_wmask), 32'd0);
        check("t1_addr", bus.mem_addr, 32'h6000_0000);
        tick();
        check("t1_rmask_t2", 32'(bus.mem_rmask), 32'd0);
        check("t1_iresp_t2", 32'(bus.imem_resp), 32'd0);
        check("t1_addr_hold", bus.mem_addr, 32'h6000_0000);
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_0013;
        #1;
        check("t1_iresp_t3", 32'(bus.imem_resp), 32'd1);
        check("t1_irdata_t3", bus.imem_rdata, 32'h0000_0013);
        check("t1_dresp_t3", 32'(bus.dmem_resp), 32'd0);
        check("t1_drdata_t3", bus.dmem_rdata, 32'd0);
        tick();
        clear_inputs();
        #1;
        check("t1_idle_after", st(dut.state_q), st(ARB_IDLE));
        check("t1_iresp_after", 32'(bus.imem_resp), 32'd0);

        // 2. Simultaneous store and fetch: data first, fetch after dmem_resp.
        bus.dmem_addr  = 32'h6000_0104;
        bus.dmem_wmask = 4'h3;
        bus.dmem_wdata = 32'h0000_BEEF;
        bus.imem_addr  = 32'h6000_0200;
        bus.imem_rmask = 4'hF;
        tick();
        check("t2_state_busy_d", st(dut.state_q), st(ARB_BUSY_D));
        check("t2_wmask", 32'(bus.mem_wmask), 32'h3);
        check("t2_rmask", 32'(bus.mem_rmask), 32'd0);
        check("t2_addr", bus.mem_addr, 32'h6000_0104);
        check("t2_wdata", bus.mem_wdata, 32'h0000_BEEF);
        check("t2_streak", 32'(dut.streak_q), 32'd1);
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hDEAD_0000;
        #1;
        check("t2_dresp", 32'(bus.dmem_resp), 32'd1);
        check("t2_iresp_blocked", 32'(bus.imem_resp), 32'd0);
        tick();
        bus.mem_resp   = 1'b0;
        bus.dmem_wmask = 4'h0;
        #1;
        check("t2_idle_gap", st(dut.state_q), st(ARB_IDLE));
        check("t2_gap_masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
        check("t2_wdata_hold", bus.mem_wdata, 32'h0000_BEEF);
        tick();
        check("t2_state_busy_i", st(dut.state_q), st(ARB_BUSY_I));
        check("t2_i_rmask", 32'(bus.mem_rmask), 32'hF);
        check("t2_i_addr", bus.mem_addr, 32'h6000_0200);
        check("t2_i_wdata", bus.mem_wdata, 32'd0);
        check("t2_i_wmask", 32'(bus.mem_wmask), 32'd0);
        check("t2_streak_clr", 32'(dut.streak_q), 32'd0);
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        #1;
        check("t2_iresp", 32'(bus.imem_resp), 32'd1);
        check("t2_irdata", bus.imem_rdata, 32'h1234_5678);
        tick();
        clear_inputs();
        #1;
        check("t2_idle_end", st(dut.state_q), st(ARB_IDLE));

        // 3. Starvation guard: both requests held continuously.
        bus.dmem_addr  = 32'h6000_0300;
        bus.dmem_rmask = 4'hF;
        bus.imem_addr  = 32'h6000_0400;
        bus.imem_rmask = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t3_grant%0d", k), st(dut.state_q),
                  exp_d[k] ? st(ARB_BUSY_D) : st(ARB_BUSY_I));
            check($sformatf("t3_streak%0d", k), 32'(dut.streak_q), 32'(exp_sk[k]));
            check($sformatf("t3_addr%0d", k), bus.mem_addr,
                  exp_d[k] ? 32'h6000_0300 : 32'h6000_0400);
            tick();
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = 32'(k);
            #1;
            check($sformatf("t3_dresp%0d", k), 32'(bus.dmem_resp), 32'(exp_d[k]));
            check($sformatf("t3_iresp%0d", k), 32'(bus.imem_resp), 32'(!exp_d[k]));
            tick();
            bus.mem_resp = 1'b0;
            #1;
            check($sformatf("t3_idle%0d", k), st(dut.state_q), st(ARB_IDLE));
        end
        clear_inputs();
        tick();
        check("t3_streak_idle_clr", 32'(dut.streak_q), 32'd0);

        // 4. Spurious mem_resp while idle.
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        #1;
        check("t4_resps", {30'd0, bus.imem_resp, bus.dmem_resp}, 32'd0);
        check("t4_rdata", bus.imem_rdata | bus.dmem_rdata, 32'd0);
        tick();
        check("t4_state", st(dut.state_q), st(ARB_IDLE));
        check("t4_masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
        clear_inputs();

        // 5. Reset during BUSY_D, including reset coinciding with mem_resp.
        bus.dmem_addr  = 32'h6000_0010;
        bus.dmem_rmask = 4'hF;
        tick();
        check("t5_busy_d", st(dut.state_q), st(ARB_BUSY_D));
        rst           = 1'b1;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hAAAA_5555;
        #1;
        check("t5_rst_resp_same", 32'(bus.dmem_resp), 32'd0);
        tick();
        rst            = 1'b0;
        bus.dmem_rmask = 4'h0;
        #1;
        check("t5_idle", st(dut.state_q), st(ARB_IDLE));
        check("t5_late_resp", {30'd0, bus.imem_resp, bus.dmem_resp}, 32'd0);
        check("t5_mem_addr", bus.mem_addr, 32'd0);
        check("t5_masks", {24'd0, bus.mem_rmask, bus.mem_wmask}, 32'd0);
        check("t5_rdata", bus.imem_rdata | bus.dmem_rdata, 32'd0);
        tick();
        clear_inputs();
        bus.imem_addr  = 32'h6000_0020;
        bus.imem_rmask = 4'hF;
        tick();
        check("t5_fetch_busy", st(dut.state_q), st(ARB_BUSY_I));
        check("t5_fetch_addr", bus.mem_addr, 32'h6000_0020);
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h00A0_0093;
        #1;
        check("t5_fetch_resp", 32'(bus.imem_resp), 32'd1);
        check("t5_fetch_rdata", bus.imem_rdata, 32'h00A0_0093);
        tick();
        clear_inputs();

        // 6. Zero-latency memory for a byte load.
        bus.dmem_addr  = 32'h6000_0008;
        bus.dmem_rmask = 4'h1;
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'h0000_0055;
        #1;
        check("t6_rmask", 32'(bus.mem_rmask), 32'h1);
        check("t6_addr", bus.mem_addr, 32'h6000_0008);
        check("t6_dresp", 32'(bus.dmem_resp), 32'd1);
        check("t6_drdata", bus.dmem_rdata, 32'h0000_0055);
        tick();
        clear_inputs();
        #1;
        check("t6_idle_t2", st(dut.state_q), st(ARB_IDLE));
        check("t6_rmask_t2", 32'(bus.mem_rmask), 32'd0);
        check("t6_dresp_t2", 32'(bus.dmem_resp), 32'd0);
        tick();
        check("t6_single_pulse", 32'(bus.mem_rmask), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported, variable-latency memory between the instruction-fetch port (imem) and the MEM-stage data port (dmem) of the rv32i pipeline.
- Grants one requester at a time and issues a one-cycle request pulse to memory.
- Waits for mem_resp, then routes the response back to the granted requester.
- Data accesses have priority; a streak limit prevents fetch starvation.

Parameters:
MAX_D_STREAK, 4, consecutive dmem grants allowed while an imem request is pending before imem must be granted (range 1..15).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
imem_addr  in  32  fetch address; held stable until imem_resp
imem_rmask  in  4  fetch read mask; nonzero = fetch request pending
imem_rdata  out  32  fetch read data; valid when imem_resp=1
imem_resp  out  1  one-cycle fetch completion pulse
dmem_addr  in  32  data address; held stable until dmem_resp
dmem_rmask  in  4  load mask
dmem_wmask  in  4  store mask; rmask|wmask nonzero = data request pending
dmem_wdata  in  32  store data
dmem_rdata  out  32  load data; valid when dmem_resp=1
dmem_resp  out  1  one-cycle data completion pulse
mem_addr  out  32  memory address, registered
mem_rmask  out  4  memory read mask; nonzero for exactly one cycle per issue
mem_wmask  out  4  memory write mask; nonzero for exactly one cycle per issue
mem_wdata  out  32  memory write data, registered
mem_rdata  in  32  memory read data, valid with mem_resp
mem_resp  in  1  memory completion pulse

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named clk and rst.
- States:
  - IDLE: no access outstanding.
  - BUSY_I: fetch access outstanding.
  - BUSY_D: data access outstanding.
- Reset: state=IDLE, streak=0. mem_addr, mem_rmask, mem_wmask and mem_wdata are 0. imem_resp=0, dmem_resp=0, and both rdata outputs are 0.
- Request detection:
  - d_req = |dmem_rmask | |dmem_wmask.
  - i_req = |imem_rmask.
  - Requests are sampled only in IDLE.
- Arbitration in IDLE, cycle t:
  - d_req and (!i_req or streak<MAX_D_STREAK): grant D.
  - else if i_req: grant I.
  - else: stay IDLE.
- On grant at edge t+1:
  - Latch the winner's addr, rmask, wmask and wdata into the mem_* registers.
  - An imem grant drives wmask=0 and wdata=0.
  - Enter BUSY_D or BUSY_I.
- mem_rmask/mem_wmask are nonzero only in the first BUSY cycle. They are cleared at the next edge; mem_addr/mem_wdata hold their value until the next grant.
- Streak counter:
  - Increments on a D grant while i_req=1, saturating at MAX_D_STREAK.
  - Clears on any I grant.
  - Clears in any IDLE cycle with i_req=0.
- Response (combinational, zero added latency):
  - In BUSY_D with mem_resp=1: dmem_resp=1, dmem_rdata=mem_rdata, next state IDLE.
  - In BUSY_I with mem_resp=1: the same on the imem side.
  - A store also pulses dmem_resp; dmem_rdata is then don't-care but driven as mem_rdata.
- Outside a matching BUSY cycle: both resp outputs are 0 and both rdata outputs are 0.
- Minimum round trip:
  - request at t → mem mask at t+1 → mem_resp at t+1 (earliest) → requester resp at t+1.
  - Next grant is decided at t+2 at the earliest.
- No back-to-back re-issue: after a resp the arbiter is IDLE for at least one cycle. A requester that keeps its request asserted after resp is treated as issuing a new request.
- mem_resp in IDLE is spurious: ignore it; no resp pulses and no state change.
- Requests arriving while BUSY are not sampled. They stay pending (level) until IDLE.
- Reset during BUSY: return to IDLE and drop the outstanding access. A late mem_resp is then ignored per the IDLE rule.
- Simultaneous rst and mem_resp: reset wins and no resp pulse is emitted.
- The requester must keep its inputs stable while its access is outstanding. The arbiter uses only latched values after grant, so changes to requester inputs during BUSY have no effect.

Decomposition:
- rv32i_types package additions:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}.
  - localparam ARB_STREAK_W = 4.
- No sub-module: a single FSM with a streak counter and a request latch.

Test Plan:
1. Lone fetch: imem_addr=0x6000_0000, rmask=4'hF at t; memory responds 2 cycles after the pulse with rdata=0x0000_0013 → mem_rmask=4'hF only at t+1; imem_resp=1 with rdata=0x13 at t+3; dmem_resp stays 0.
2. Simultaneous requests: d_req (store addr 0x6000_0104, wmask=4'h3, wdata=0xBEEF) and i_req at t → D granted first with mem_wmask=4'h3 and mem_rmask=0. The I grant is issued only after dmem_resp.
3. Starvation guard with MAX_D_STREAK=4: d_req and i_req held continuously with 1-cycle memory → grant order D,D,D,D,I,D…; streak returns to 0 after the I grant.
4. Spurious mem_resp in IDLE with no requests pending → no resp pulses, state stays IDLE, mem masks stay 0.
5. rst asserted in BUSY_D, mem_resp the next cycle → dmem_resp never pulses; all outputs are 0 the cycle after reset; a new fetch afterwards completes normally.
6. Zero-latency memory (mem_resp in the same cycle as the pulse) for a load with addr 0x6000_0008, rmask=4'h1 → dmem_resp at t+1, IDLE at t+2, exactly one mem pulse issued.
